half_adder: RTL and testbench



---
 rtl/half_adder.sv | 59 +++++
 tb/tb_half_adder.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/half_adder.sv
// half_adder: parameterised unsigned half adder, {carry_out, sum_out} = a_in + b_in.
// At WIDTH = 1 this is the classic cell (sum = a ^ b, carry = a & b).
//
// Parameters:
//   WIDTH    operand/sum width in bits, legal range 1..64
//   OUT_REG  1 = registered outputs (1-cycle latency), 0 = purely combinational
//
// Ports:
//   clk_in     clock, rising edge (unused when OUT_REG = 0)
//   rst_n_in   asynchronous active-low reset (unused when OUT_REG = 0)
//   a_in       operand A, unsigned
//   b_in       operand B, unsigned
//   sum_out    low WIDTH bits of a_in + b_in
//   carry_out  bit WIDTH of a_in + b_in
module half_adder #(
    parameter int unsigned WIDTH   = 1,
    parameter bit          OUT_REG = 1'b1
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out
);

    localparam int unsigned SUM_W = WIDTH + 1;

    // Full-width sum; the extra MSB is the carry out.
    logic [SUM_W-1:0] w_sum;

    assign w_sum = SUM_W'(a_in) + SUM_W'(b_in);

    generate
        if (OUT_REG) begin : g_reg
            // Sum and carry share one register so they always belong to the same operand pair.
            logic [SUM_W-1:0] r_sum;

            always_ff @(posedge clk_in or negedge rst_n_in) begin
                if (!rst_n_in) begin
                    r_sum <= '0;
                end else begin
                    r_sum <= w_sum;
                end
            end

            assign sum_out   = r_sum[WIDTH-1:0];
            assign carry_out = r_sum[WIDTH];
        end else begin : g_comb
            // Clock and reset have no role in the combinational build.
            logic w_unused;

            assign w_unused  = clk_in ^ rst_n_in;
            assign sum_out   = w_sum[WIDTH-1:0];
            assign carry_out = w_sum[WIDTH];
        end
    endgenerate

endmodule

// File: tb/tb_half_adder.sv
// tb_half_adder: directed and random checks of half_adder in four builds:
// 1-bit registered, 8-bit registered, 64-bit registered, 4-bit combinational.
module tb_half_adder;

    logic        clk;
    logic        rst_n;
    logic        rst_c_n;

    logic        a1, b1, s1, c1;
    logic [7:0]  a8, b8, s8;
    logic        c8;
    logic [3:0]  a4, b4, s4;
    logic        c4;
    logic [63:0] a64, b64, s64;
    logic        c64;

    int n_cmp  = 0;
    int n_fail = 0;

    half_adder #(.WIDTH(1), .OUT_REG(1'b1)) u_w1 (
        .clk_in(clk), .rst_n_in(rst_n), .a_in(a1), .b_in(b1), .sum_out(s1), .carry_out(c1)
    );
    half_adder #(.WIDTH(8), .OUT_REG(1'b1)) u_w8 (
        .clk_in(clk), .rst_n_in(rst_n), .a_in(a8), .b_in(b8), .sum_out(s8), .carry_out(c8)
    );
    half_adder #(.WIDTH(64), .OUT_REG(1'b1)) u_w64 (
        .clk_in(clk), .rst_n_in(rst_n), .a_in(a64), .b_in(b64), .sum_out(s64), .carry_out(c64)
    );
    half_adder #(.WIDTH(4), .OUT_REG(1'b0)) u_w4c (
        .clk_in(clk), .rst_n_in(rst_c_n), .a_in(a4), .b_in(b4), .sum_out(s4), .carry_out(c4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: sum is the wrapped total; carry set when a exceeds the headroom left above b.
    function automatic logic [64:0] ref_add(input int w, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] mask;
        logic [63:0] sum;
        logic        cy;
        mask = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        a    = a & mask;
        b    = b & mask;
        sum  = (a + b) & mask;
        cy   = (a > (mask - b));
        return {cy, sum};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_pair(input string tag, input int w, input logic [63:0] s, input logic c,
                              input logic [64:0] exp);
        check({tag, ".sum"}, s, exp[63:0]);
        check({tag, ".carry"}, 64'(c), 64'(exp[64]));
    endtask

    initial begin
        logic [64:0] e1, e8, e64, prev1, prev8, prev64;
        logic [1:0]  tt;

        rst_n = 1'b1; rst_c_n = 1'b1;
        a1 = 1'b1; b1 = 1'b0;
        a8 = 8'h00; b8 = 8'h00; a64 = '0; b64 = '0; a4 = '0; b4 = '0;

        // Reset held with a=1, b=0: outputs forced to 0/0
        #1 rst_n = 1'b0;
        #1 check_pair("rst_immediate_w1", 1, 64'(s1), c1, 65'd0);
        repeat (2) @(posedge clk);
        #1;
        check_pair("rst_held_w1", 1, 64'(s1), c1, 65'd0);
        check_pair("rst_held_w8", 8, 64'(s8), c8, 65'd0);
        check_pair("rst_held_w64", 64, s64, c64, 65'd0);

        // Release; first edge captures current operands
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_pair("rst_release_w1", 1, 64'(s1), c1, {1'b0, 64'd1});

        // Exhaustive 1-bit truth table
        for (int i = 0; i < 4; i++) begin
            tt = 2'(i);
            a1 = tt[1]; b1 = tt[0];
            @(posedge clk); #1;
            check_pair($sformatf("truth_%0d%0d", a1, b1), 1, 64'(s1), c1, ref_add(1, 64'(a1), 64'(b1)));
        end

        // 8-bit and 64-bit wrap corners
        a8 = 8'hFF; b8 = 8'h01; a64 = {64{1'b1}}; b64 = 64'd1;
        @(posedge clk); #1;
        check_pair("wrap8_ff_01", 8, 64'(s8), c8, {1'b1, 64'h00});
        check_pair("wrap64_max_1", 64, s64, c64, {1'b1, 64'd0});
        a8 = 8'h80; b8 = 8'h7F; a64 = 64'h8000_0000_0000_0000; b64 = 64'h7FFF_FFFF_FFFF_FFFF;
        @(posedge clk); #1;
        check_pair("wrap8_80_7f", 8, 64'(s8), c8, {1'b0, 64'hFF});
        check_pair("wrap64_half", 64, s64, c64, {1'b0, {64{1'b1}}});
        a8 = 8'hFF; b8 = 8'hFF; a64 = {64{1'b1}}; b64 = {64{1'b1}};
        @(posedge clk); #1;
        check_pair("wrap8_ff_ff", 8, 64'(s8), c8, {1'b1, 64'hFE});
        check_pair("wrap64_max_max", 64, s64, c64, {1'b1, 64'hFFFF_FFFF_FFFF_FFFE});

        // Back-to-back random operands every cycle: outputs hold until the edge, then show that pair
        prev1  = ref_add(1, 64'(a1), 64'(b1));
        prev8  = ref_add(8, 64'(a8), 64'(b8));
        prev64 = ref_add(64, a64, b64);
        for (int i = 0; i < 24; i++) begin
            a1 = 1'($urandom); b1 = 1'($urandom);
            a8 = 8'($urandom); b8 = 8'($urandom);
            a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
            if (i % 6 == 5) b64 = ~a64 + 64'd1;
            #1;
            check_pair($sformatf("hold_w1_%0d", i), 1, 64'(s1), c1, prev1);
            check_pair($sformatf("hold_w8_%0d", i), 8, 64'(s8), c8, prev8);
            @(posedge clk); #1;
            e1  = ref_add(1, 64'(a1), 64'(b1));
            e8  = ref_add(8, 64'(a8), 64'(b8));
            e64 = ref_add(64, a64, b64);
            check_pair($sformatf("b2b_w1_%0d", i), 1, 64'(s1), c1, e1);
            check_pair($sformatf("b2b_w8_%0d", i), 8, 64'(s8), c8, e8);
            check_pair($sformatf("b2b_w64_%0d", i), 64, s64, c64, e64);
            prev1 = e1; prev8 = e8; prev64 = e64;
        end

        // Async reset mid-stream: 1+1 gives 0/1, then reset between edges clears at once
        a1 = 1'b1; b1 = 1'b1;
        @(posedge clk); #1;
        check_pair("pre_async_w1", 1, 64'(s1), c1, {1'b1, 64'd0});
        #1 rst_n = 1'b0;
        #1;
        check_pair("async_rst_w1", 1, 64'(s1), c1, 65'd0);
        check_pair("async_rst_w64", 64, s64, c64, 65'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_pair("post_async_w1", 1, 64'(s1), c1, {1'b1, 64'd0});

        // Combinational 4-bit build: no clock edge, reset ignored
        a4 = 4'hA; b4 = 4'h7;
        #1;
        check_pair("comb_a_7", 4, 64'(s4), c4, {1'b1, 64'h1});
        rst_c_n = 1'b0;
        #1;
        check_pair("comb_rst_low", 4, 64'(s4), c4, {1'b1, 64'h1});
        rst_c_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            a4 = 4'($urandom); b4 = 4'($urandom);
            rst_c_n = 1'($urandom);
            #1;
            check_pair($sformatf("comb_rand_%0d", i), 4, 64'(s4), c4, ref_add(4, 64'(a4), 64'(b4)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
